// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS datapath: multiply/divide
// operation and state encodings, funct codes, and sign helpers.
package mips_pkg;

  // Helpers work on a 64-bit carrier. Callers zero-extend a narrower value
  // and truncate the result, which keeps the arithmetic exact modulo 2^w for
  // any w up to 64.
  localparam int MD_XW = 64;

  localparam logic [5:0] FUNCT_MULT = 6'h18;
  localparam logic [5:0] FUNCT_DIV  = 6'h1A;

  typedef enum logic {
    MD_MULT = 1'b0,
    MD_DIV  = 1'b1
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } md_state_t;

  // Two's complement negation.
  function automatic logic [MD_XW-1:0] neg_w(input logic [MD_XW-1:0] v);
    return ~v + 64'd1;
  endfunction

  // Magnitude of a value whose sign bit is passed separately.
  // The most negative value maps onto itself, which reads correctly as unsigned.
  function automatic logic [MD_XW-1:0] abs_w(input logic [MD_XW-1:0] v,
                                             input logic s);
    return s ? neg_w(v) : v;
  endfunction

endpackage

// File: rtl/mult_div_ctrl.sv
// Signed multi-cycle multiply/divide unit holding HI/LO.
// Shift-add multiply and restoring divide run on magnitudes for WIDTH
// cycles, then a single FIX cycle applies the signs and writes HI/LO.
//
//   state | meaning
//   IDLE  | waiting for start; HI/LO hold the last result
//   CALC  | one shift-add or restore-divide step per cycle, WIDTH cycles
//   FIX   | sign correction, HI/LO written
//   DONE  | done pulse for one cycle, then back to IDLE
module mult_div_ctrl
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int AW = 2 * WIDTH;

  md_state_t        state_q;
  md_op_t           op_q;
  logic             sa_q, sb_q;
  logic [CW-1:0]    cnt_q;
  logic [AW-1:0]    acc_q;
  logic [WIDTH-1:0] mag_q;
  logic             busy_q, done_q, div_zero_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [AW-1:0]    mul_acc_d;
  logic [AW-1:0]    div_sh;
  logic [WIDTH:0]   div_diff;
  logic [AW-1:0]    div_acc_d;
  logic [AW-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // Operand magnitudes and one iteration of each algorithm, plus the sign fix.
  always_comb begin
    a_mag = WIDTH'(abs_w(MD_XW'(a), a[WIDTH-1]));
    b_mag = WIDTH'(abs_w(MD_XW'(b), b[WIDTH-1]));

    // Multiply: multiplier sits in the low half and is consumed LSB-first;
    // the partial sum keeps its carry as the accumulator shifts right.
    mul_sum = {1'b0, acc_q[AW-1:WIDTH]};
    if (acc_q[0]) begin
      mul_sum = mul_sum + {1'b0, mag_q};
    end
    mul_acc_d = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: remainder in the high half, dividend/quotient in the low half.
    // The remainder stays below the divisor magnitude, so the shift never
    // drops a set bit off the top.
    div_sh    = {acc_q[AW-2:0], 1'b0};
    div_diff  = {1'b0, div_sh[AW-1:WIDTH]} - {1'b0, mag_q};
    div_acc_d = div_diff[WIDTH] ? div_sh
                                : {div_diff[WIDTH-1:0], div_sh[WIDTH-1:1], 1'b1};

    prod_fix = (sa_q ^ sb_q) ? AW'(neg_w(MD_XW'(acc_q))) : acc_q;
    quo_fix  = (sa_q ^ sb_q) ? WIDTH'(neg_w(MD_XW'(acc_q[WIDTH-1:0])))
                             : acc_q[WIDTH-1:0];
    rem_fix  = sa_q ? WIDTH'(neg_w(MD_XW'(acc_q[AW-1:WIDTH])))
                    : acc_q[AW-1:WIDTH];
  end

  // Sequencer FSM with registered status outputs and HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= MD_MULT;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
      mag_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            op_q       <= md_op_t'(op);
            sa_q       <= a[WIDTH-1];
            sb_q       <= b[WIDTH-1];
            cnt_q      <= '0;
            div_zero_q <= 1'b0;
            busy_q     <= 1'b1;
            if (op && (b == '0)) begin
              div_zero_q <= 1'b1;
              done_q     <= 1'b1;
              state_q    <= DONE;
            end else begin
              acc_q   <= op ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
              mag_q   <= op ? b_mag : a_mag;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          acc_q <= (op_q == MD_DIV) ? div_acc_d : mul_acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          if (op_q == MD_DIV) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[AW-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Directed bench for mult_div_ctrl: expected HI/LO come from 64-bit signed
// arithmetic, queued at start and checked when done pulses.
module tb_mult_div_ctrl;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, op;
  logic [31:0] a, b;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t        sbq[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  mult_div_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic o, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    longint      sx, sy, q, r;
    logic [63:0] p, qv, rv;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (!o) begin
      p    = 64'(sx * sy);
      e.hi = p[63:32];
      e.lo = p[31:0];
      e.dz = 1'b0;
    end else if (y == 32'd0) begin
      e.hi = model_hi;
      e.lo = model_lo;
      e.dz = 1'b1;
    end else begin
      q    = sx / sy;
      r    = sx % sy;
      qv   = 64'(q);
      rv   = 64'(r);
      e.lo = qv[31:0];
      e.hi = rv[31:0];
      e.dz = 1'b0;
    end
    model_hi = e.hi;
    model_lo = e.lo;
    sbq.push_back(e);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the
  // first IDLE cycle after done, so consecutive calls start back-to-back.
  task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y,
                        input int glitch_at, input string tag);
    int   lat;
    bit   seen;
    exp_t e;
    lat  = (o && (y == 32'd0)) ? 1 : 34;
    seen = 1'b0;
    op = o; a = x; b = y; start = 1'b1;
    push_exp(o, x, y);
    for (int n = 1; n <= 60 && !seen; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == glitch_at) begin
        start = 1'b1; op = ~o; a = 32'h9; b = 32'h3;
      end
      if (n == 1) chk({tag, "/dz_c1"}, 64'(div_zero), 64'(o && (y == 32'd0)));
      chk({tag, "/busy"}, 64'(busy), 64'd1);
      if (done) begin
        seen = 1'b1;
        chk({tag, "/latency"}, 64'(n), 64'(lat));
        e = sbq.pop_front();
        chk({tag, "/hi"}, 64'(hi), 64'(e.hi));
        chk({tag, "/lo"}, 64'(lo), 64'(e.lo));
        chk({tag, "/div_zero"}, 64'(div_zero), 64'(e.dz));
      end
    end
    start = 1'b0;
    if (!seen) begin
      chk({tag, "/timeout"}, 64'd0, 64'd1);
      if (sbq.size() > 0) void'(sbq.pop_front());
    end
    @(negedge clk);
    chk({tag, "/idle_busy"}, 64'(busy), 64'd0);
    chk({tag, "/idle_done"}, 64'(done), 64'd0);
  endtask

  initial begin
    bit any_done;
    reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst/busy", 64'(busy), 64'd0);
    chk("rst/done", 64'(done), 64'd0);
    chk("rst/div_zero", 64'(div_zero), 64'd0);
    chk("rst/hi", 64'(hi), 64'd0);
    chk("rst/lo", 64'(lo), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(1'b0, 32'd7, 32'hFFFF_FFFD, 0, "mul_7_m3");
    chk("mul_7_m3/hi_const", 64'(hi), 64'hFFFF_FFFF);
    chk("mul_7_m3/lo_const", 64'(lo), 64'hFFFF_FFEB);
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 0, "mul_min_min");
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0, "div_m7_2");
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    run_op(1'b0, 32'd5, 32'd6, 0, "mul_5_6");
    run_op(1'b1, 32'd1234, 32'd0, 0, "div_zero");
    chk("div_zero/hi_kept", 64'(hi), 64'd0);
    chk("div_zero/lo_kept", 64'(lo), 64'd30);
    run_op(1'b1, 32'd100, 32'd7, 0, "div_after_dz");
    run_op(1'b0, 32'd123, 32'hFFFF_FE38, 5, "mul_glitch");
    run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 0, "div_min_min");
    run_op(1'b1, 32'd5, 32'h8000_0000, 0, "div_5_min");
    for (int i = 0; i < 6; i++) begin
      run_op(1'(i & 1), $urandom, $urandom | 32'd1, 0, "rand");
    end

    // Reset in the middle of a divide discards the result.
    op = 1'b1; a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid/busy", 64'(busy), 64'd0);
    chk("rst_mid/done", 64'(done), 64'd0);
    chk("rst_mid/div_zero", 64'(div_zero), 64'd0);
    chk("rst_mid/hi", 64'(hi), 64'd0);
    chk("rst_mid/lo", 64'(lo), 64'd0);
    reset = 1'b0;
    model_hi = '0;
    model_lo = '0;
    any_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) any_done = 1'b1;
    end
    chk("rst_mid/no_done", 64'(any_done), 64'd0);
    run_op(1'b0, 32'd3, 32'd4, 0, "mul_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
